// File: rtl/div16_seq_ctrl_if.sv
// Handshake and data bundle for the sequential 32/16 unsigned divider.
interface div16_seq_ctrl_if;
    logic        start;
    logic [15:0] dividend_hi;
    logic [15:0] dividend_lo;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic        div_err;
    logic [15:0] quotient;
    logic [15:0] remainder;

    modport master (
        output start, dividend_hi, dividend_lo, divisor,
        input  busy, done, div_err, quotient, remainder
    );

    modport slave (
        input  start, dividend_hi, dividend_lo, divisor,
        output busy, done, div_err, quotient, remainder
    );
endinterface

// File: rtl/div16_seq_ctrl.sv
// Sequential restoring divider: {dividend_hi,dividend_lo} / divisor, one quotient bit per cycle.
// done and div_err are registered, so they appear the cycle after the DONE state.
module div16_seq_ctrl (
    input  logic               clk,
    input  logic               rst,
    div16_seq_ctrl_if.slave    div_if
);

    typedef enum logic [1:0] {StIdle, StCheck, StRun, StDone} state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [15:0] r_hi;
    logic [15:0] r_lo;
    logic [15:0] r_divisor;
    logic [15:0] r_prem;
    logic [3:0]  r_cnt;
    logic        r_err;
    logic        r_div_err;
    logic        r_done;
    logic [15:0] r_quot;
    logic [15:0] r_rem;

    logic        w_err_check;
    logic [16:0] w_shift;
    logic [16:0] w_diff;
    logic        w_borrow;
    logic        w_busy;
    logic        w_accept;
    logic        w_check;
    logic        w_step;
    logic        w_finish;

    always_comb begin
        w_err_check = (r_divisor == 16'h0000) || (r_hi >= r_divisor);
        w_shift     = {r_prem, r_lo[15]};
        w_diff      = w_shift - {1'b0, r_divisor};
        // A set shifted MSB always exceeds the divisor; otherwise bit 16 of the difference is the borrow.
        w_borrow    = ~w_shift[16] & w_diff[16];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (div_if.start) w_state_next = StCheck;
            StCheck: w_state_next = w_err_check ? StDone : StRun;
            StRun:   if (r_cnt == 4'd15) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_busy   = 1'b0;
        w_accept = 1'b0;
        w_check  = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            StIdle:  w_accept = div_if.start;
            StCheck: begin
                w_busy  = 1'b1;
                w_check = 1'b1;
            end
            StRun: begin
                w_busy = 1'b1;
                w_step = 1'b1;
            end
            StDone: begin
                w_busy   = 1'b1;
                w_finish = 1'b1;
            end
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi      <= 16'h0000;
            r_lo      <= 16'h0000;
            r_divisor <= 16'h0000;
            r_prem    <= 16'h0000;
            r_cnt     <= 4'd0;
            r_err     <= 1'b0;
            r_div_err <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= 16'h0000;
            r_rem     <= 16'h0000;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_hi      <= div_if.dividend_hi;
                r_lo      <= div_if.dividend_lo;
                r_divisor <= div_if.divisor;
                r_div_err <= 1'b0;
            end
            if (w_check) begin
                r_err  <= w_err_check;
                r_prem <= r_hi;
                r_cnt  <= 4'd0;
            end
            // r_lo doubles as the quotient shift register: dividend bits leave the top, quotient bits enter the bottom.
            if (w_step) begin
                r_prem <= w_borrow ? w_shift[15:0] : w_diff[15:0];
                r_lo   <= {r_lo[14:0], ~w_borrow};
                r_cnt  <= r_cnt + 4'd1;
            end
            if (w_finish) begin
                if (r_err) begin
                    r_div_err <= 1'b1;
                end else begin
                    r_quot <= r_lo;
                    r_rem  <= r_prem;
                end
            end
        end
    end

    assign div_if.busy      = w_busy;
    assign div_if.done      = r_done;
    assign div_if.div_err   = r_div_err;
    assign div_if.quotient  = r_quot;
    assign div_if.remainder = r_rem;

endmodule

// File: tb/tb_div16_seq_ctrl.sv
// Scoreboard bench for div16_seq_ctrl: driver pushes expected results, monitor checks each done pulse.
module tb_div16_seq_ctrl;

    typedef struct {
        logic        err;
        logic [15:0] q;
        logic [15:0] r;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div16_seq_ctrl_if dif ();

    div16_seq_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (dif)
    );

    exp_t        sb[$];
    exp_t        m_e;
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    logic [15:0] mq        = 16'h0000;
    logic [15:0] mr        = 16'h0000;
    bit          hold_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation, on its due cycle.
    always @(posedge clk) begin
        #1;
        if (dif.done === 1'b1) begin
            if (sb.size() == 0) begin
                fail_now("spurious_done");
            end else begin
                m_e = sb.pop_front();
                chk("div_err", {31'b0, dif.div_err}, {31'b0, m_e.err});
                chk("quotient", {16'b0, dif.quotient}, {16'b0, m_e.q});
                chk("remainder", {16'b0, dif.remainder}, {16'b0, m_e.r});
                chk("latency", cyc, m_e.due);
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            fail_now("done_timeout");
            void'(sb.pop_front());
        end
    end

    task automatic noise();
        dif.start       = hold_mode ? 1'b1 : 1'($urandom_range(0, 1));
        dif.dividend_hi = 16'($urandom);
        dif.dividend_lo = 16'($urandom);
        dif.divisor     = 16'($urandom);
    endtask

    // Called and returns at a negedge; start is seen by the DUT at the following posedge.
    task automatic issue(input logic [15:0] hi, input logic [15:0] lo, input logic [15:0] dv);
        int          w;
        exp_t        e;
        logic [31:0] dd;
        w = 0;
        while (dif.busy && w < 100) begin
            noise();
            @(negedge clk);
            w++;
        end
        if (dif.busy) fail_now("idle_wait");
        dif.dividend_hi = hi;
        dif.dividend_lo = lo;
        dif.divisor     = dv;
        dif.start       = 1'b1;
        dd = {hi, lo};
        if (dv == 16'h0000 || hi >= dv) begin
            e = '{1'b1, mq, mr, cyc + 1 + 2};
        end else begin
            mq = 16'(dd / {16'h0000, dv});
            mr = 16'(dd % {16'h0000, dv});
            e  = '{1'b0, mq, mr, cyc + 1 + 18};
        end
        sb.push_back(e);
        @(negedge clk);
        chk("busy_after_start", {31'b0, dif.busy}, 32'd1);
        chk("err_cleared_on_start", {31'b0, dif.div_err}, 32'd0);
        noise();
    endtask

    task automatic idle(input int k);
        int w;
        w = 0;
        while (dif.busy && w < 100) begin
            noise();
            @(negedge clk);
            w++;
        end
        dif.start = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() > 0 || dif.busy) && w < 200) begin
            if (dif.busy) noise();
            else dif.start = 1'b0;
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        dif.start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, dif.busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, dif.done}, 32'd0);
        chk({tag, "_div_err"}, {31'b0, dif.div_err}, 32'd0);
        chk({tag, "_quotient"}, {16'b0, dif.quotient}, 32'd0);
        chk({tag, "_remainder"}, {16'b0, dif.remainder}, 32'd0);
    endtask

    initial begin
        int          e_cyc;
        logic [15:0] dv;
        logic [15:0] hi;
        rst             = 1'b1;
        dif.start       = 1'b1;
        dif.dividend_hi = 16'h0000;
        dif.dividend_lo = 16'h0000;
        dif.divisor     = 16'h0000;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst       = 1'b0;
        dif.start = 1'b0;
        @(negedge clk);

        issue(16'h0000, 16'h0064, 16'h0007);
        issue(16'hFFFE, 16'hFFFF, 16'hFFFF);
        issue(16'h0005, 16'h1234, 16'h0005);
        issue(16'h1234, 16'h5678, 16'h0000);
        issue(16'h0000, 16'h0064, 16'h0007);
        idle(2);
        drain();

        // Abort 0x0001_0000 / 2 just as RUN iteration 8 would execute.
        e_cyc = cyc + 1;
        issue(16'h0001, 16'h0000, 16'h0002);
        while (cyc < e_cyc + 9) begin
            noise();
            @(negedge clk);
        end
        rst       = 1'b1;
        dif.start = 1'b0;
        sb.delete();
        mq = 16'h0000;
        mr = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid_run_reset");
        repeat (25) @(negedge clk);
        issue(16'h0001, 16'h0000, 16'h0002);
        drain();

        for (int i = 0; i < 40; i++) begin
            hold_mode = (i >= 20);
            case ($urandom_range(0, 9))
                0: begin
                    dv = 16'h0000;
                    hi = 16'($urandom);
                end
                1: begin
                    dv = 16'($urandom_range(1, 16'hFFFF));
                    hi = 16'($urandom_range(dv, 16'hFFFF));
                end
                2: begin
                    dv = 16'($urandom_range(1, 15));
                    hi = 16'($urandom_range(0, dv - 1));
                end
                default: begin
                    dv = 16'($urandom_range(1, 16'hFFFF));
                    hi = 16'($urandom_range(0, dv - 1));
                end
            endcase
            issue(hi, 16'($urandom), dv);
            if (!hold_mode && $urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
        end
        hold_mode = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div16_seq_ctrl.md
DIV16_SEQ_CTRL -- requirements
Module: div16_seq_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 SHALL provide port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL provide port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL provide port dividend_hi, input, 16 bits: upper dividend word (DX).
REQ-006 SHALL provide port dividend_lo, input, 16 bits: lower dividend word (AX).
REQ-007 SHALL provide port divisor, input, 16 bits: unsigned divisor.
REQ-008 SHALL provide port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-009 SHALL provide port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL provide port div_err, output, 1 bit: divide error flag, valid with done.
REQ-011 SHALL provide port quotient, output, 16 bits: unsigned quotient.
REQ-012 SHALL provide port remainder, output, 16 bits: unsigned remainder.

Function
REQ-013 SHALL compute the unsigned 32/16 division {dividend_hi,dividend_lo} / divisor, producing a 16-bit quotient and a 16-bit remainder.
REQ-014 SHALL implement FSM states IDLE, CHECK, RUN and DONE.
REQ-015 SHALL, in IDLE with start=1, register both dividend words and the divisor, then go to CHECK; start while not IDLE SHALL be ignored.
REQ-016 SHALL, in CHECK, flag an error when divisor==0 or dividend_hi >= divisor (quotient overflow), using the registered operands.
REQ-017 SHALL, on an error in CHECK, go to DONE; otherwise it SHALL load partial remainder = {1'b0, dividend_hi}, clear the 4-bit iteration counter, and go to RUN.
REQ-018 SHALL, in each RUN cycle, perform one restoring step:
  - shift the partial remainder left by one, inserting the next dividend_lo bit (MSB first);
  - perform a 17-bit trial subtraction of {1'b0, divisor};
  - if there is no borrow, keep the difference and set quotient bit 1; otherwise restore the shifted value and set quotient bit 0.
REQ-019 SHALL perform exactly 16 RUN iterations; after the iteration with counter==15 it SHALL go to DONE.
REQ-020 SHALL hold all intermediate arithmetic to 17 bits and SHALL NOT carry a partial remainder of more than 16 significant bits into the next step.
REQ-021 SHALL, in DONE, assert done for exactly one cycle and return to IDLE on the next edge.
REQ-022 SHALL set quotient and remainder in DONE on success and hold them until the next successful completion.
REQ-023 SHALL, on error, assert div_err=1 and leave quotient and remainder at their previous values.
REQ-024 SHALL hold div_err until the next accepted start, which clears it.
REQ-025 SHALL have a latency of 18 cycles on success: start sampled at edge 0, done high in the cycle after edge 18.
REQ-026 SHALL have a latency of 2 cycles on error.
REQ-027 SHALL drive busy=1 in CHECK, RUN and DONE, and busy=0 in IDLE.
REQ-028 SHALL accept a start asserted in the cycle immediately after done (back-to-back operation).
REQ-029 SHALL keep operand changes after acceptance from affecting an operation in progress.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, force state IDLE, busy=0, done=0, div_err=0, quotient=0x0000, remainder=0x0000, and counter=0.
REQ-031 SHALL, on rst asserted mid-operation (CHECK or RUN), abort the operation without asserting done; the first start after rst deasserts SHALL be accepted normally.
REQ-032 SHALL give rst priority over start when both are asserted in the same cycle.

Verification
REQ-033 SHALL verify: dividend_hi=0x0000, dividend_lo=0x0064, divisor=0x0007 -> quotient=0x000E, remainder=0x0002, div_err=0, done 18 cycles after start.
REQ-034 SHALL verify: dividend=0xFFFE_FFFF, divisor=0xFFFF -> quotient=0xFFFF, remainder=0xFFFE, div_err=0.
REQ-035 SHALL verify: dividend_hi=0x0005, divisor=0x0005 -> div_err=1 and done 2 cycles after start, with quotient and remainder unchanged from the prior result.
REQ-036 SHALL verify: divisor=0x0000 with any dividend -> div_err=1; a following valid start clears div_err.
REQ-037 SHALL verify: rst pulsed at RUN iteration 8 of 0x0001_0000/0x0002 -> no done, all outputs at 0; a rerun yields quotient=0x8000, remainder=0x0000.
REQ-038 SHALL verify: start held high continuously across two operations -> second operation accepted the cycle after done, and start pulses during busy are ignored.
